// File: rtl/decode_stage_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_pipelined
// Purpose  : Pipelined decode stage between fetch and execute. Extracts the
//            instruction fields, reads the scalar and vector register files,
//            and broadcasts a scalar to every lane for vector-scalar ops.
//            The ID/EX register uses a valid/ready handshake. A per-register
//            scoreboard stalls RAW hazards. Writeback bypasses to the reads,
//            and a flush is supported.
// Ports    : clock, reset (sync, active-high), flush
//            in_valid/in_ready/instruction  - fetch side handshake
//            wb_*                           - writeback into the register files
//            out_valid/out_ready, out_*     - registered ID/EX outputs
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage_pipelined #(
    parameter int SCALAR_DATA_WIDTH = 48,
    parameter int VECTOR_DATA_WIDTH = 8,
    parameter int VECTOR_SIZE       = 6,
    parameter int SCALAR_REGNUM     = 16,
    parameter int VECTOR_REGNUM     = 16,
    parameter int ADDRESS_WIDTH     = 4,
    parameter int OPCODE_WIDTH      = 4,
    parameter int INSTRUCTION_WIDTH = 48
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     flush,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [INSTRUCTION_WIDTH-1:0]             instruction,
    input  logic                                     wb_we_scalar,
    input  logic                                     wb_we_vector,
    input  logic [ADDRESS_WIDTH-1:0]                 wb_addr,
    input  logic [SCALAR_DATA_WIDTH-1:0]             wb_scalar_data,
    input  logic [VECTOR_SIZE*VECTOR_DATA_WIDTH-1:0] wb_vector_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [OPCODE_WIDTH-1:0]                  out_opcode,
    output logic [ADDRESS_WIDTH-1:0]                 out_dest,
    output logic [ADDRESS_WIDTH-1:0]                 out_src1,
    output logic [ADDRESS_WIDTH-1:0]                 out_src2,
    output logic                                     out_isVector,
    output logic                                     out_isVectorScalar,
    output logic                                     out_writesReg,
    output logic [SCALAR_DATA_WIDTH-1:0]             out_imm,
    output logic [SCALAR_DATA_WIDTH-1:0]             out_s1,
    output logic [SCALAR_DATA_WIDTH-1:0]             out_s2,
    output logic [VECTOR_SIZE*VECTOR_DATA_WIDTH-1:0] out_v1,
    output logic [VECTOR_SIZE*VECTOR_DATA_WIDTH-1:0] out_v2
);

    localparam int c_VDW       = VECTOR_SIZE * VECTOR_DATA_WIDTH;
    localparam int c_OP_LSB    = INSTRUCTION_WIDTH - OPCODE_WIDTH;
    localparam int c_DEST_LSB  = c_OP_LSB - ADDRESS_WIDTH;
    localparam int c_SRC1_LSB  = c_DEST_LSB - ADDRESS_WIDTH;
    localparam int c_SRC2_LSB  = c_SRC1_LSB - ADDRESS_WIDTH;
    localparam int c_ISV_BIT   = c_SRC2_LSB - 1;
    localparam int c_ISVS_BIT  = c_SRC2_LSB - 2;
    localparam int c_WR_BIT    = c_SRC2_LSB - 3;
    localparam int c_IMM_W     = c_SRC2_LSB - 4;

    // ---------------- field extraction ----------------
    logic [OPCODE_WIDTH-1:0]      w_opcode;
    logic [ADDRESS_WIDTH-1:0]     w_dest, w_src1, w_src2;
    logic                         w_isv, w_isvs, w_wr;
    logic [SCALAR_DATA_WIDTH-1:0] w_imm;
    logic                         w_unused_bit;

    assign w_opcode     = instruction[c_OP_LSB   +: OPCODE_WIDTH];
    assign w_dest       = instruction[c_DEST_LSB +: ADDRESS_WIDTH];
    assign w_src1       = instruction[c_SRC1_LSB +: ADDRESS_WIDTH];
    assign w_src2       = instruction[c_SRC2_LSB +: ADDRESS_WIDTH];
    assign w_isv        = instruction[c_ISV_BIT];
    assign w_isvs       = instruction[c_ISVS_BIT];
    assign w_wr         = instruction[c_WR_BIT];
    assign w_imm        = {{(SCALAR_DATA_WIDTH-c_IMM_W){instruction[c_IMM_W-1]}},
                           instruction[c_IMM_W-1:0]};
    // The bit between writesReg and imm carries no meaning in this encoding.
    assign w_unused_bit = instruction[c_IMM_W];

    // ---------------- state ----------------
    logic [SCALAR_DATA_WIDTH-1:0] rf_scalar_q [SCALAR_REGNUM];
    logic [SCALAR_DATA_WIDTH-1:0] rf_scalar_d [SCALAR_REGNUM];
    logic [c_VDW-1:0]             rf_vector_q [VECTOR_REGNUM];
    logic [c_VDW-1:0]             rf_vector_d [VECTOR_REGNUM];
    logic [SCALAR_REGNUM-1:0]     sb_scalar_q, sb_scalar_d;
    logic [VECTOR_REGNUM-1:0]     sb_vector_q, sb_vector_d;

    logic                         out_valid_q, out_valid_d;
    logic [OPCODE_WIDTH-1:0]      out_opcode_q, out_opcode_d;
    logic [ADDRESS_WIDTH-1:0]     out_dest_q, out_dest_d;
    logic [ADDRESS_WIDTH-1:0]     out_src1_q, out_src1_d;
    logic [ADDRESS_WIDTH-1:0]     out_src2_q, out_src2_d;
    logic                         out_isv_q, out_isv_d;
    logic                         out_isvs_q, out_isvs_d;
    logic                         out_wr_q, out_wr_d;
    logic [SCALAR_DATA_WIDTH-1:0] out_imm_q, out_imm_d;
    logic [SCALAR_DATA_WIDTH-1:0] out_s1_q, out_s1_d;
    logic [SCALAR_DATA_WIDTH-1:0] out_s2_q, out_s2_d;
    logic [c_VDW-1:0]             out_v1_q, out_v1_d;
    logic [c_VDW-1:0]             out_v2_q, out_v2_d;

    // ---------------- operand reads with writeback bypass ----------------
    logic                         w_wbs_src1, w_wbs_src2, w_wbv_src1, w_wbv_src2;
    logic [SCALAR_DATA_WIDTH-1:0] w_rd_s1, w_rd_s2;
    logic [c_VDW-1:0]             w_rd_v1, w_rd_v2_vec, w_bcast, w_rd_v2;

    assign w_wbs_src1  = wb_we_scalar && (wb_addr == w_src1);
    assign w_wbs_src2  = wb_we_scalar && (wb_addr == w_src2);
    assign w_wbv_src1  = wb_we_vector && (wb_addr == w_src1);
    assign w_wbv_src2  = wb_we_vector && (wb_addr == w_src2);

    assign w_rd_s1     = w_wbs_src1 ? wb_scalar_data : rf_scalar_q[w_src1];
    assign w_rd_s2     = w_wbs_src2 ? wb_scalar_data : rf_scalar_q[w_src2];
    assign w_rd_v1     = w_wbv_src1 ? wb_vector_data : rf_vector_q[w_src1];
    assign w_rd_v2_vec = w_wbv_src2 ? wb_vector_data : rf_vector_q[w_src2];

    for (genvar l = 0; l < VECTOR_SIZE; l++) begin : g_bcast
        assign w_bcast[l*VECTOR_DATA_WIDTH +: VECTOR_DATA_WIDTH] = w_rd_s2[VECTOR_DATA_WIDTH-1:0];
    end

    assign w_rd_v2 = (w_isv && w_isvs) ? w_bcast : w_rd_v2_vec;

    // ---------------- hazard detection ----------------
    // src2 is a scalar operand unless the op is a pure vector-vector op.
    logic w_src1_vec, w_src2_vec;
    logic w_sb1, w_sb2, w_idex1, w_idex2, w_hazard;
    logic w_accept, w_issue;

    assign w_src1_vec = w_isv;
    assign w_src2_vec = w_isv && !w_isvs;

    // A same-cycle writeback releases the pending bit early; the bypass
    // above supplies the value.
    assign w_sb1 = w_src1_vec ? (sb_vector_q[w_src1] && !w_wbv_src1)
                              : (sb_scalar_q[w_src1] && !w_wbs_src1);
    assign w_sb2 = w_src2_vec ? (sb_vector_q[w_src2] && !w_wbv_src2)
                              : (sb_scalar_q[w_src2] && !w_wbs_src2);

    // Producer still sitting in ID/EX has not set its scoreboard bit yet.
    assign w_idex1 = out_valid_q && out_wr_q && (out_dest_q == w_src1) && (out_isv_q == w_src1_vec);
    assign w_idex2 = out_valid_q && out_wr_q && (out_dest_q == w_src2) && (out_isv_q == w_src2_vec);

    assign w_hazard = w_sb1 || w_sb2 || w_idex1 || w_idex2;
    assign in_ready = !flush && !w_hazard && (!out_valid_q || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_issue  = out_valid_q && out_ready && !flush;

    // ---------------- next-state logic ----------------
    always_comb begin
        rf_scalar_d = rf_scalar_q;
        rf_vector_d = rf_vector_q;
        if (wb_we_scalar) rf_scalar_d[wb_addr] = wb_scalar_data;
        if (wb_we_vector) rf_vector_d[wb_addr] = wb_vector_data;

        // Clear first, then set, so a newer producer wins over a retiring one.
        sb_scalar_d = sb_scalar_q;
        sb_vector_d = sb_vector_q;
        if (wb_we_scalar) sb_scalar_d[wb_addr] = 1'b0;
        if (wb_we_vector) sb_vector_d[wb_addr] = 1'b0;
        if (w_issue && out_wr_q) begin
            if (out_isv_q) sb_vector_d[out_dest_q] = 1'b1;
            else           sb_scalar_d[out_dest_q] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_opcode_d = out_opcode_q;
        out_dest_d   = out_dest_q;
        out_src1_d   = out_src1_q;
        out_src2_d   = out_src2_q;
        out_isv_d    = out_isv_q;
        out_isvs_d   = out_isvs_q;
        out_wr_d     = out_wr_q;
        out_imm_d    = out_imm_q;
        out_s1_d     = out_s1_q;
        out_s2_d     = out_s2_q;
        out_v1_d     = out_v1_q;
        out_v2_d     = out_v2_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (w_accept) begin
            out_valid_d  = 1'b1;
            out_opcode_d = w_opcode;
            out_dest_d   = w_dest;
            out_src1_d   = w_src1;
            out_src2_d   = w_src2;
            out_isv_d    = w_isv;
            out_isvs_d   = w_isvs;
            out_wr_d     = w_wr;
            out_imm_d    = w_imm;
            out_s1_d     = w_rd_s1;
            out_s2_d     = w_rd_s2;
            out_v1_d     = w_rd_v1;
            out_v2_d     = w_rd_v2;
        end else if (w_issue) begin
            out_valid_d = 1'b0;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SCALAR_REGNUM; i++) rf_scalar_q[i] <= '0;
            for (int i = 0; i < VECTOR_REGNUM; i++) rf_vector_q[i] <= '0;
            sb_scalar_q  <= '0;
            sb_vector_q  <= '0;
            out_valid_q  <= 1'b0;
            out_opcode_q <= '0;
            out_dest_q   <= '0;
            out_src1_q   <= '0;
            out_src2_q   <= '0;
            out_isv_q    <= 1'b0;
            out_isvs_q   <= 1'b0;
            out_wr_q     <= 1'b0;
            out_imm_q    <= '0;
            out_s1_q     <= '0;
            out_s2_q     <= '0;
            out_v1_q     <= '0;
            out_v2_q     <= '0;
        end else begin
            rf_scalar_q  <= rf_scalar_d;
            rf_vector_q  <= rf_vector_d;
            sb_scalar_q  <= sb_scalar_d;
            sb_vector_q  <= sb_vector_d;
            out_valid_q  <= out_valid_d;
            out_opcode_q <= out_opcode_d;
            out_dest_q   <= out_dest_d;
            out_src1_q   <= out_src1_d;
            out_src2_q   <= out_src2_d;
            out_isv_q    <= out_isv_d;
            out_isvs_q   <= out_isvs_d;
            out_wr_q     <= out_wr_d;
            out_imm_q    <= out_imm_d;
            out_s1_q     <= out_s1_d;
            out_s2_q     <= out_s2_d;
            out_v1_q     <= out_v1_d;
            out_v2_q     <= out_v2_d;
        end
    end

    assign out_valid          = out_valid_q;
    assign out_opcode         = out_opcode_q;
    assign out_dest           = out_dest_q;
    assign out_src1           = out_src1_q;
    assign out_src2           = out_src2_q;
    assign out_isVector       = out_isv_q;
    assign out_isVectorScalar = out_isvs_q;
    assign out_writesReg      = out_wr_q;
    assign out_imm            = out_imm_q;
    assign out_s1             = out_s1_q;
    assign out_s2             = out_s2_q;
    assign out_v1             = out_v1_q;
    assign out_v2             = out_v2_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage_pipelined
// Purpose  : Self-checking bench for decode_stage_pipelined. A register-level
//            reference model (register values, pending-producer sets and the
//            held ID/EX instruction) predicts in_ready and all outputs.
//            Directed scenarios run first, followed by a random phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage_pipelined;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [47:0] instruction;
    logic        wb_we_scalar, wb_we_vector;
    logic [3:0]  wb_addr;
    logic [47:0] wb_scalar_data, wb_vector_data;
    logic [3:0]  out_opcode, out_dest, out_src1, out_src2;
    logic        out_isVector, out_isVectorScalar, out_writesReg;
    logic [47:0] out_imm, out_s1, out_s2, out_v1, out_v2;

    always #5 clock = ~clock;

    decode_stage_pipelined dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
        .wb_we_scalar(wb_we_scalar), .wb_we_vector(wb_we_vector), .wb_addr(wb_addr),
        .wb_scalar_data(wb_scalar_data), .wb_vector_data(wb_vector_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_dest(out_dest), .out_src1(out_src1), .out_src2(out_src2),
        .out_isVector(out_isVector), .out_isVectorScalar(out_isVectorScalar),
        .out_writesReg(out_writesReg), .out_imm(out_imm),
        .out_s1(out_s1), .out_s2(out_s2), .out_v1(out_v1), .out_v2(out_v2)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0]  op, dest, a1, a2;
        logic        isv, isvs, wr;
        logic [47:0] imm, s1, s2, v1, v2;
    } idex_t;

    logic [47:0] m_rf   [2][16];   // [0] scalar file, [1] vector file
    logic        m_pend [2][16];   // issued producers awaiting writeback
    logic        m_ov;
    idex_t       m_x;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] mk(input logic [3:0] op, input logic [3:0] d,
                                       input logic [3:0] s1, input logic [3:0] s2,
                                       input logic v, input logic vs, input logic wr,
                                       input logic [27:0] imm);
        return {op, d, s1, s2, v, vs, wr, 1'b0, imm};
    endfunction

    function automatic logic wb_hits(input int file, input logic [3:0] a);
        return (file == 0) ? (wb_we_scalar && wb_addr == a) : (wb_we_vector && wb_addr == a);
    endfunction

    function automatic logic [47:0] m_read(input int file, input logic [3:0] a);
        if (wb_hits(file, a)) return (file == 0) ? wb_scalar_data : wb_vector_data;
        return m_rf[file][a];
    endfunction

    function automatic logic m_ready();
        logic [3:0] a [2];
        int         f [2];
        logic       blocked;
        a[0] = instruction[39:36];
        a[1] = instruction[35:32];
        f[0] = instruction[31] ? 1 : 0;
        f[1] = (instruction[31] && !instruction[30]) ? 1 : 0;
        blocked = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (m_pend[f[k]][a[k]] && !wb_hits(f[k], a[k])) blocked = 1'b1;
            if (m_ov && m_x.wr && m_x.dest == a[k] && ((m_x.isv ? 1 : 0) == f[k])) blocked = 1'b1;
        end
        return !flush && !blocked && (!m_ov || out_ready);
    endfunction

    task automatic m_step();
        idex_t       nx;
        logic        acc, iss;
        logic [47:0] sv;
        nx = '0;
        if (reset) begin
            for (int f = 0; f < 2; f++)
                for (int r = 0; r < 16; r++) begin
                    m_rf[f][r]   = '0;
                    m_pend[f][r] = 1'b0;
                end
            m_ov = 1'b0;
            m_x  = '0;
            return;
        end
        acc = in_valid && m_ready();
        iss = m_ov && out_ready && !flush;
        if (acc) begin
            nx.op   = instruction[47:44];
            nx.dest = instruction[43:40];
            nx.a1   = instruction[39:36];
            nx.a2   = instruction[35:32];
            nx.isv  = instruction[31];
            nx.isvs = instruction[30];
            nx.wr   = instruction[29];
            nx.imm  = {{20{instruction[27]}}, instruction[27:0]};
            nx.s1   = m_read(0, nx.a1);
            nx.s2   = m_read(0, nx.a2);
            nx.v1   = m_read(1, nx.a1);
            sv      = nx.s2;
            nx.v2   = (nx.isv && nx.isvs) ? {6{sv[7:0]}} : m_read(1, nx.a2);
        end
        if (wb_we_scalar) m_pend[0][wb_addr] = 1'b0;
        if (wb_we_vector) m_pend[1][wb_addr] = 1'b0;
        if (iss && m_x.wr) m_pend[m_x.isv ? 1 : 0][m_x.dest] = 1'b1;
        if (wb_we_scalar) m_rf[0][wb_addr] = wb_scalar_data;
        if (wb_we_vector) m_rf[1][wb_addr] = wb_vector_data;
        if (flush)      m_ov = 1'b0;
        else if (acc) begin
            m_ov = 1'b1;
            m_x  = nx;
        end else if (iss) m_ov = 1'b0;
    endtask

    task automatic chk_outs();
        check("out_valid", out_valid, m_ov);
        if (m_ov) begin
            check("fields", {out_opcode, out_dest, out_src1, out_src2, out_isVector,
                             out_isVectorScalar, out_writesReg},
                  {m_x.op, m_x.dest, m_x.a1, m_x.a2, m_x.isv, m_x.isvs, m_x.wr});
            check("out_imm", out_imm, m_x.imm);
            check("out_s1", out_s1, m_x.s1);
            check("out_s2", out_s2, m_x.s2);
            check("out_v1", out_v1, m_x.v1);
            check("out_v2", out_v2, m_x.v2);
        end
    endtask

    // One clock: check in_ready mid-cycle, advance the model, check outputs after the edge.
    task automatic cyc();
        @(negedge clock);
        if (!reset) check("in_ready", in_ready, m_ready());
        m_step();
        @(posedge clock);
        #1;
        chk_outs();
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; out_ready = 1; instruction = '0;
        wb_we_scalar = 0; wb_we_vector = 0; wb_addr = '0;
        wb_scalar_data = '0; wb_vector_data = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] r64;

        // ---- reset state ----
        reset = 1; idle();
        cyc(); cyc();
        reset = 0;
        check("rst_out_valid", out_valid, 0);
        check("rst_opcode", out_opcode, 0);
        check("rst_s1", out_s1, 0);
        check("rst_imm", out_imm, 0);
        check("rst_v2", out_v2, 0);
        #1 check("rst_in_ready", in_ready, 1);

        // ---- 1: scalar ADD r3 = r1 + r2 with preloaded operands ----
        wb_we_scalar = 1; wb_addr = 1; wb_scalar_data = 48'd5; cyc();
        wb_addr = 2; wb_scalar_data = 48'd7; cyc();
        wb_we_scalar = 0;
        instruction = mk(4'h1, 4'd3, 4'd1, 4'd2, 0, 0, 1, 28'hFFF_FFF0);
        in_valid = 1; cyc();
        in_valid = 0;
        check("add_valid", out_valid, 1);
        check("add_s1", out_s1, 48'd5);
        check("add_s2", out_s2, 48'd7);
        check("add_imm_sext", out_imm, 48'hFFFF_FFFF_FFF0);

        // ---- 2: RAW on r4, released by same-cycle writeback ----
        instruction = mk(4'h2, 4'd4, 4'd5, 4'd5, 0, 0, 1, 28'd0);
        in_valid = 1; cyc();
        instruction = mk(4'h3, 4'd8, 4'd4, 4'd0, 0, 0, 1, 28'd5);
        cyc();
        #1 check("raw_stall", in_ready, 0);
        cyc(); cyc();
        wb_we_scalar = 1; wb_addr = 4; wb_scalar_data = 48'h123;
        cyc();
        wb_we_scalar = 0; in_valid = 0;
        check("raw_bypass_valid", out_valid, 1);
        check("raw_bypass_s1", out_s1, 48'h123);

        // ---- 3: vector-scalar broadcast, independent pending bits ----
        wb_we_scalar = 1; wb_addr = 6; wb_scalar_data = 48'h1234_5678_9AA5; cyc();
        wb_we_scalar = 0;
        instruction = mk(4'h5, 4'd6, 4'd8, 4'd9, 1, 0, 1, 28'd0);
        in_valid = 1; cyc();
        in_valid = 0; cyc();
        instruction = mk(4'h6, 4'd10, 4'd7, 4'd6, 1, 1, 1, 28'd0);
        in_valid = 1;
        #1 check("vs_scalar_free", in_ready, 1);
        cyc();
        in_valid = 0;
        check("vs_bcast", out_v2, {6{8'hA5}});
        instruction = mk(4'h7, 4'd11, 4'd6, 4'd0, 1, 0, 0, 28'd0);
        #1 check("vec_r6_pending", in_ready, 0);
        wb_we_vector = 1; wb_addr = 6; wb_vector_data = 48'hCAFE_0000_BEEF; cyc();
        wb_we_vector = 0;

        // ---- 4: output stall holds ID/EX, release accepts next ----
        out_ready = 0;
        instruction = mk(4'h8, 4'd12, 4'd1, 4'd2, 0, 0, 0, 28'h123);
        in_valid = 1; cyc();
        instruction = mk(4'h9, 4'd13, 4'd1, 4'd2, 0, 0, 0, 28'h7);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall_opcode", out_opcode, 4'h8);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1; cyc();
        check("release_opcode", out_opcode, 4'h9);
        check("release_imm", out_imm, 48'h7);

        // ---- 5: dependent chain, flush mid-stall keeps pending bit ----
        instruction = mk(4'hA, 4'd13, 4'd1, 4'd2, 0, 0, 1, 28'd0);
        cyc();
        out_ready = 0;
        instruction = mk(4'hB, 4'd14, 4'd13, 4'd1, 0, 0, 0, 28'd0);
        cyc(); cyc();
        out_ready = 1; cyc();
        instruction = mk(4'hC, 4'd15, 4'd1, 4'd2, 0, 0, 0, 28'd0);
        cyc();
        out_ready = 0;
        instruction = mk(4'hB, 4'd14, 4'd13, 4'd1, 0, 0, 0, 28'd0);
        cyc();
        flush = 1; cyc();
        flush = 0;
        check("flush_kills", out_valid, 0);
        cyc();
        #1 check("flush_sb_kept", in_ready, 0);
        wb_we_scalar = 1; wb_addr = 13; wb_scalar_data = 48'hABC;
        cyc();
        wb_we_scalar = 0; in_valid = 0;
        check("post_flush_s1", out_s1, 48'hABC);

        // ---- 6: reset while pending and holding ----
        reset = 1; cyc();
        reset = 0;
        check("rst2_valid", out_valid, 0);
        instruction = mk(4'h1, 4'd1, 4'd3, 4'd8, 0, 0, 0, 28'd0);
        #1 check("rst2_in_ready", in_ready, 1);
        out_ready = 1;
        instruction = mk(4'h1, 4'd2, 4'd1, 4'd2, 0, 0, 0, 28'd0);
        in_valid = 1; cyc();
        in_valid = 0;
        check("rst2_rf_cleared", out_s1, 0);

        // ---- random phase against the model ----
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 149) == 0);
            flush       = ($urandom_range(0, 19) == 0);
            out_ready   = flush ? 1'b0 : ($urandom_range(0, 3) != 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            r64         = {$urandom, $urandom};
            instruction = mk(r64[3:0], 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                             4'($urandom_range(0, 3)), r64[4], r64[5], r64[6], r64[63:36]);
            wb_we_scalar = ($urandom_range(0, 2) == 0);
            wb_we_vector = ($urandom_range(0, 2) == 0);
            wb_addr      = 4'($urandom_range(0, 3));
            r64 = {$urandom, $urandom}; wb_scalar_data = r64[47:0];
            r64 = {$urandom, $urandom}; wb_vector_data = r64[47:0];
            cyc();
        end

        idle(); reset = 0;
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
